// File: rtl/mips_pkg.sv
// Shared MIPS definitions: word width, instruction-memory geometry, HALT/error encodings, loader states.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package mips_pkg;

    localparam int LEN        = 32;
    localparam int IMEM_DEPTH = 64;
    localparam int NB_ADDR    = $clog2(IMEM_DEPTH);

    // Decode treats this word as halt; the loader uses it as the end-of-program marker.
    localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;

    // Status byte returned to the host when memory fills without a HALT word.
    localparam logic [7:0]  ERR_BYTE  = 8'hEE;

    // Loader FSM states, kept here so debug-dump logic can decode them.
    typedef enum logic [2:0] {
        LD_IDLE,
        LD_RECV,
        LD_WRITE,
        LD_ACK_SEND,
        LD_ACK_WAIT,
        LD_FINISH
    } loader_state_t;

endpackage

// File: rtl/byte_packer.sv
// Packs received UART bytes little-endian into instruction words; first byte lands in [7:0].
// Latency: word_valid/word are combinational with the last byte's rx_done strobe.
// Backpressure: none; bytes presented while enable is low are dropped.
module byte_packer
    import mips_pkg::*;
#(
    parameter int LEN = mips_pkg::LEN
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           clear,
    input  logic           enable,
    input  logic           rx_done,
    input  logic [7:0]     byte_in,
    output logic           word_valid,
    output logic [LEN-1:0] word
);

    localparam int NB_CNT = $clog2(LEN / 8);

    // Holds the bytes received so far, newest at the top; only LEN-8 bits are ever needed.
    logic [LEN-9:0]    shreg;
    logic [NB_CNT-1:0] byte_cnt;

    // The incoming byte completes the word on top of what is already shifted in.
    assign word       = {byte_in, shreg};
    assign word_valid = enable && rx_done && (byte_cnt == '1);

    // Shift in each accepted byte; the counter wraps to 0 on the last byte of a word.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shreg    <= '0;
            byte_cnt <= '0;
        end else if (clear) begin
            shreg    <= '0;
            byte_cnt <= '0;
        end else if (enable && rx_done) begin
            shreg    <= word[LEN-1:8];
            byte_cnt <= byte_cnt + NB_CNT'(1);
        end
    end

endmodule

// File: rtl/program_loader.sv
// Loads a program from UART into instruction memory, one word per four bytes, then returns a status byte.
// Latency: write 1 cycle after 4th byte; tx_start 1 cycle after the final write; done 1 cycle after tx_done.
// Backpressure: none; bytes outside the receive state are dropped, start outside idle is ignored.
module program_loader
    import mips_pkg::*;
#(
    parameter int               LEN       = mips_pkg::LEN,
    parameter int               NB_ADDR   = mips_pkg::NB_ADDR,
    parameter logic [LEN-1:0]   HALT_WORD = mips_pkg::HALT_WORD,
    parameter logic [7:0]       ERR_BYTE  = mips_pkg::ERR_BYTE
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               rx_done,
    input  logic [7:0]         uart_data_in,
    input  logic               tx_done,
    output logic               tx_start,
    output logic [7:0]         uart_data_out,
    output logic               mem_we,
    output logic [NB_ADDR-1:0] mem_addr,
    output logic [LEN-1:0]     mem_wdata,
    output logic               busy,
    output logic               done,
    output logic               overflow_err
);

    loader_state_t      state, state_next;
    logic [7:0]         word_cnt, word_cnt_next;
    logic [NB_ADDR-1:0] mem_addr_next;
    logic [LEN-1:0]     mem_wdata_next;
    logic [7:0]         uart_data_out_next;
    logic               overflow_next;
    logic               packer_clear;
    logic               packer_en;
    logic               word_valid;
    logic [LEN-1:0]     word;

    assign packer_clear = (state == LD_IDLE) && start;
    assign packer_en    = (state == LD_RECV);

    byte_packer #(
        .LEN (LEN)
    ) u_byte_packer (
        .clk        (clk),
        .reset      (reset),
        .clear      (packer_clear),
        .enable     (packer_en),
        .rx_done    (rx_done),
        .byte_in    (uart_data_in),
        .word_valid (word_valid),
        .word       (word)
    );

    // Next-state and next-register values; the status byte is staged directly in uart_data_out.
    always_comb begin
        state_next         = state;
        word_cnt_next      = word_cnt;
        mem_addr_next      = mem_addr;
        mem_wdata_next     = mem_wdata;
        uart_data_out_next = uart_data_out;
        overflow_next      = overflow_err;
        case (state)
            LD_IDLE: begin
                if (start) begin
                    mem_addr_next = '0;
                    word_cnt_next = '0;
                    overflow_next = 1'b0;
                    state_next    = LD_RECV;
                end
            end
            LD_RECV: begin
                if (word_valid) begin
                    mem_wdata_next = word;
                    state_next     = LD_WRITE;
                end
            end
            LD_WRITE: begin
                word_cnt_next = word_cnt + 8'd1;
                // HALT wins over overflow: a HALT in the last slot is a clean finish.
                if (mem_wdata == HALT_WORD) begin
                    uart_data_out_next = word_cnt + 8'd1;
                    state_next         = LD_ACK_SEND;
                end else if (mem_addr == {NB_ADDR{1'b1}}) begin
                    overflow_next      = 1'b1;
                    uart_data_out_next = ERR_BYTE;
                    state_next         = LD_ACK_SEND;
                end else begin
                    mem_addr_next = mem_addr + NB_ADDR'(1);
                    state_next    = LD_RECV;
                end
            end
            LD_ACK_SEND: begin
                state_next = LD_ACK_WAIT;
            end
            LD_ACK_WAIT: begin
                if (tx_done) begin
                    state_next = LD_FINISH;
                end
            end
            LD_FINISH: begin
                state_next = LD_IDLE;
            end
            default: begin
                state_next = LD_IDLE;
            end
        endcase
    end

    // State and registered outputs; strobes are decoded from the state being entered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= LD_IDLE;
            word_cnt      <= '0;
            mem_addr      <= '0;
            mem_wdata     <= '0;
            uart_data_out <= '0;
            overflow_err  <= 1'b0;
            mem_we        <= 1'b0;
            tx_start      <= 1'b0;
            done          <= 1'b0;
            busy          <= 1'b0;
        end else begin
            state         <= state_next;
            word_cnt      <= word_cnt_next;
            mem_addr      <= mem_addr_next;
            mem_wdata     <= mem_wdata_next;
            uart_data_out <= uart_data_out_next;
            overflow_err  <= overflow_next;
            mem_we        <= (state_next == LD_WRITE);
            tx_start      <= (state_next == LD_ACK_SEND);
            done          <= (state_next == LD_FINISH);
            busy          <= (state_next != LD_IDLE) && (state_next != LD_FINISH);
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader with a write scoreboard.
// Latency: n/a.
// Backpressure: n/a.
module tb_program_loader;
    import mips_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        rx_done = 1'b0;
    logic [7:0]  uart_data_in = 8'h00;
    logic        tx_done = 1'b0;
    logic        tx_start;
    logic [7:0]  uart_data_out;
    logic        mem_we;
    logic [5:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        busy;
    logic        done;
    logic        overflow_err;

    typedef struct {
        logic [5:0]  addr;
        logic [31:0] data;
    } wr_t;

    wr_t sb[$];
    int  n_checks = 0;
    int  n_pass = 0;
    int  n_fail = 0;
    int  cyc = 0;
    int  last_we_cyc = -100;
    logic prev_we = 1'b0;

    program_loader dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .rx_done       (rx_done),
        .uart_data_in  (uart_data_in),
        .tx_done       (tx_done),
        .tx_start      (tx_start),
        .uart_data_out (uart_data_out),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .busy          (busy),
        .done          (done),
        .overflow_err  (overflow_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Write monitor: every mem_we must match the head of the scoreboard and last one cycle.
    always @(negedge clk) begin
        if (!reset && mem_we) begin
            check("we_single_cycle", 64'(prev_we), 64'd0);
            check("write_expected", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) begin
                check("write_addr", 64'(mem_addr), 64'(sb[0].addr));
                check("write_data", 64'(mem_wdata), 64'(sb[0].data));
                void'(sb.pop_front());
            end
            last_we_cyc <= cyc;
        end
        prev_we <= mem_we & ~reset;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic send_byte(input logic [7:0] b, input bit last);
        @(negedge clk);
        rx_done = 1'b1;
        uart_data_in = b;
        @(negedge clk);
        rx_done = 1'b0;
        if (last) check("we_latency", 64'(mem_we), 64'd1);
        else repeat (2) @(negedge clk);
    endtask

    task automatic send_word(input logic [31:0] w, input logic [5:0] a);
        wr_t e;
        e.addr = a;
        e.data = w;
        sb.push_back(e);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], i == 3);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", 64'(busy), 64'd1);
        check("ovf_cleared_on_start", 64'(overflow_err), 64'd0);
        check("addr_cleared_on_start", 64'(mem_addr), 64'd0);
    endtask

    task automatic finish_load(input logic [7:0] st, input bit ovf);
        int n = 0;
        while (tx_start !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("tx_start_seen", 64'(tx_start), 64'd1);
        check("we_to_tx_latency", 64'(cyc - last_we_cyc), 64'd1);
        check("status_byte", 64'(uart_data_out), 64'(st));
        check("overflow_err", 64'(overflow_err), 64'(ovf));
        // A stray byte while waiting for the transmitter must be dropped.
        @(negedge clk);
        rx_done = 1'b1;
        uart_data_in = 8'h77;
        @(negedge clk);
        rx_done = 1'b0;
        check("tx_start_one_cycle", 64'(tx_start), 64'd0);
        @(negedge clk);
        check("status_hold", 64'(uart_data_out), 64'(st));
        check("busy_in_ack_wait", 64'(busy), 64'd1);
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
        check("done_after_tx_done", 64'(done), 64'd1);
        check("busy_low_at_done", 64'(busy), 64'd0);
        @(negedge clk);
        check("done_one_cycle", 64'(done), 64'd0);
        check("scoreboard_drained", 64'(sb.size()), 64'd0);
    endtask

    initial begin
        // Reset state.
        repeat (2) @(negedge clk);
        check("reset_outputs",
              {13'd0, tx_start, mem_we, busy, done, overflow_err, mem_addr, mem_wdata, uart_data_out},
              64'd0);
        reset = 1'b0;

        // Three-word program ending in HALT.
        pulse_start();
        send_word(32'h1234_5678, 6'd0);
        send_word(32'hDEAD_BEEF, 6'd1);
        send_word(32'hFFFF_FFFF, 6'd2);
        finish_load(8'h03, 1'b0);

        // Fill memory without a HALT word.
        pulse_start();
        for (int i = 0; i < 64; i++) send_word(32'hA500_0000 | 32'(i), 6'(i));
        finish_load(8'hEE, 1'b1);
        check("addr_no_wrap", 64'(mem_addr), 64'd63);

        // Back-to-back load clears the previous overflow and counts afresh.
        pulse_start();
        send_word(32'hFFFF_FFFF, 6'd0);
        finish_load(8'h01, 1'b0);

        // Reset in the middle of a word.
        pulse_start();
        send_word(32'h0BAD_F00D, 6'd0);
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("reset_mid_load",
              {13'd0, tx_start, mem_we, busy, done, overflow_err, mem_addr, mem_wdata, uart_data_out},
              64'd0);
        @(negedge clk);
        reset = 1'b0;
        pulse_start();
        send_word(32'hFFFF_FFFF, 6'd0);
        finish_load(8'h01, 1'b0);

        // Bytes in idle, a byte coinciding with start, and start during receive are all ignored.
        send_byte(8'h55, 1'b0);
        send_byte(8'h66, 1'b0);
        check("idle_ignores_rx", 64'(busy), 64'd0);
        @(negedge clk);
        start = 1'b1;
        rx_done = 1'b1;
        uart_data_in = 8'h99;
        @(negedge clk);
        start = 1'b0;
        rx_done = 1'b0;
        check("busy_after_start_with_byte", 64'(busy), 64'd1);
        begin
            wr_t e;
            e.addr = 6'd0;
            e.data = 32'hCAFE_F00D;
            sb.push_back(e);
        end
        send_byte(8'h0D, 1'b0);
        send_byte(8'hF0, 1'b0);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("start_in_recv_ignored", 64'(mem_addr), 64'd0);
        send_byte(8'hFE, 1'b0);
        send_byte(8'hCA, 1'b1);
        repeat (2) @(negedge clk);
        send_word(32'h0102_0304, 6'd1);
        send_word(32'hFFFF_FFFF, 6'd2);
        finish_load(8'h03, 1'b0);

        repeat (3) @(negedge clk);
        check("final_scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/program_loader.md
# program_loader

Receives a MIPS program from the host over the UART receive path and writes it into instruction memory. It packs four received bytes into each 32-bit instruction word and writes the words to consecutive addresses. Loading ends on a HALT word or when memory is full, and the block then returns one status byte over the UART transmit path. It sits between `uart` and the instruction-memory write port, and is armed by the debug control FSM before the pipeline is released with `reset_mips`.

## Interface
Parameters:
- `LEN`, 32, instruction word width (must be a multiple of 8)
- `NB_ADDR`, 6, instruction-memory address width (64 words)
- `HALT_WORD`, 32'hFFFF_FFFF, end-of-program marker
- `ERR_BYTE`, 8'hEE, status byte sent on overflow

Ports:
- `clk`  in  1  system clock (CLK100MHZ domain)
- `reset`  in  1  asynchronous, active-high reset
- `start`  in  1  one-cycle pulse that arms a load
- `rx_done`  in  1  one-cycle strobe from `uart`: `uart_data_in` is valid
- `uart_data_in`  in  8  received byte
- `tx_done`  in  1  one-cycle strobe from `uart`: transmission finished
- `tx_start`  out  1  one-cycle pulse requesting transmission of `uart_data_out`
- `uart_data_out`  out  8  status byte
- `mem_we`  out  1  instruction-memory write enable
- `mem_addr`  out  NB_ADDR  write address
- `mem_wdata`  out  LEN  write data
- `busy`  out  1  high from the cycle after `start` until the cycle `done` pulses
- `done`  out  1  one-cycle pulse when the load is complete
- `overflow_err`  out  1  sticky; memory filled without a HALT word; cleared by the next `start`

## Operation
- States: IDLE, RECV, WRITE, ACK_SEND, ACK_WAIT, FINISH.
- IDLE:
  - `start` clears the address, byte counter, word counter and `overflow_err`, then moves to RECV.
  - `rx_done` and `tx_done` are ignored.
- RECV:
  - Each `rx_done` shifts `uart_data_in` into the word register, little-endian: the first byte goes to [7:0], the fourth to [31:24].
  - The 2-bit byte counter increments on each `rx_done`. On the fourth byte it wraps to 0 and the state moves to WRITE.
- WRITE (one cycle):
  - `mem_we`=1, with `mem_wdata` = the assembled word and `mem_addr` = the current address.
  - The word counter increments.
  - Word == `HALT_WORD`: status byte = word count including the HALT word, low 8 bits; next state ACK_SEND.
  - Otherwise, if `mem_addr` == 2^NB_ADDR−1: set `overflow_err`; status byte = `ERR_BYTE`; next state ACK_SEND.
  - Otherwise: address increments; next state RECV.
- ACK_SEND (one cycle): `tx_start`=1, `uart_data_out` = status byte; next state ACK_WAIT.
- ACK_WAIT: `uart_data_out` holds the status byte; `tx_done` moves the state to FINISH.
- FINISH (one cycle): `done`=1, `busy`=0; next state IDLE.
- `start` outside IDLE is ignored. `rx_done` outside RECV is dropped; a complete word takes far longer than the WRITE/ACK states, so this only drops stray bytes.
- The HALT word is itself written to memory, so fetch stops on it.

## Timing
- Reset values: state IDLE; `tx_start`, `mem_we`, `busy`, `done`, `overflow_err` = 0; `mem_addr`, `mem_wdata`, `uart_data_out` = 0.
- All outputs are registered.
- `mem_we` rises in the cycle after the fourth `rx_done` and lasts exactly one cycle. `mem_addr`/`mem_wdata` are stable during that cycle.
- Address update: `mem_addr` advances on the edge that ends WRITE.
- HALT/overflow word to `tx_start`: the cycle after WRITE (1 cycle).
- `tx_done` to `done`: 1 cycle.
- Reset asserted mid-load immediately returns the block to IDLE with all outputs at reset values. Memory contents already written remain.
- A byte arriving in the same cycle as `start` is not captured.

## Structure
- Shared package (`mips_pkg`) holds:
  - `LEN`
  - instruction-memory depth and address width
  - `HALT_WORD` encoding, shared with `decode`, which treats it as halt
  - `ERR_BYTE`
  - the loader state enumeration, for debug-dump reuse
- One natural sub-module, `byte_packer`: a shift register plus 2-bit counter that emits a `word_valid` strobe and the assembled word. The FSM stays in `program_loader`.

## Test plan
- Load 3 words: `start`, then bytes 78 56 34 12, EF BE AD DE, FF FF FF FF. Required: writes of 0x12345678 @0, 0xDEADBEEF @1, 0xFFFFFFFF @2; `tx_start` with `uart_data_out`=0x03; `done` one cycle after `tx_done`; `overflow_err`=0.
- Overflow: send 64 non-HALT words (256 bytes). Required: 64 writes to addresses 0..63; `overflow_err`=1; status byte 0xEE; address does not wrap to 0.
- Reset mid-word: 2 bytes, then `reset` pulse, then `start` and HALT bytes. Required: no `mem_we` before reset; the HALT word is written @0 and the status byte is 0x01.
- Ignored events: `rx_done` in IDLE and `start` during RECV. Required: no state change and no extra writes; the in-progress word is unaffected.
- Back-to-back loads: a second `start` after `done`. Required: address restarts at 0, `overflow_err` from the previous load is cleared, and the status byte reflects only the new load.
